ucu_pe_v2: RTL

Parametrised successor of the systolic compute unit. Each instance holds one signed-feature input register chain and one MAC datapath with saturating accumulation. It uses a ping-pong pair of output banks. Compared with the previous unit it adds a generalised stride delay chain (strides 1..MAX_STRIDE), a self-timed valid/ready drain port for the inactive bank, and guarded bank swapping. It sits in the PE grid between its east/south neighbours and the upper unit that consumes `psum_up`.

---
 rtl/ucu_pe_v2.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ucu_pe_v2.sv
// Systolic PE with a stride-delay input chain, saturating MAC, and ping-pong output banks.
// The inactive bank is drained over a valid/ready port; bank swaps are refused while a drain is running.
module ucu_pe_v2 #(
  parameter int FW         = 8,
  parameter int AW         = 32,
  parameter int DEPTH      = 32,
  parameter int MAX_STRIDE = 4,
  parameter int IS_BOTTOM  = 0
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic                     freeze,
  input  logic [2:0]               in_sel,
  input  logic [1:0]               stride,
  input  logic [FW-1:0]            x_bus,
  input  logic                     x_valid,
  input  logic [FW-1:0]            shift_e,
  input  logic [FW-1:0]            shift_s,
  input  logic [FW-1:0]            w,
  input  logic [AW-1:0]            psum_low,
  input  logic                     acc_we,
  input  logic [$clog2(DEPTH)-1:0] wr_pos,
  input  logic [$clog2(DEPTH)-1:0] rd_pos,
  input  logic                     do_scale,
  input  logic [4:0]               scale,
  input  logic                     swap,
  input  logic                     drain_start,
  input  logic                     drain_ready,
  output logic [FW-1:0]            shift_w,
  output logic [FW-1:0]            shift_n,
  output logic [AW-1:0]            psum_up,
  output logic [AW-1:0]            drain_data,
  output logic                     drain_valid,
  output logic                     drain_busy,
  output logic                     drain_done,
  output logic                     swap_err,
  output logic                     bank
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CH  = (MAX_STRIDE > 1) ? MAX_STRIDE - 1 : 1;
  localparam int SW  = AW + 2;
  localparam int PRW = 2 * FW;

  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_X      = 3'd1,
    SEL_BACKUP = 3'd2,
    SEL_E      = 3'd3,
    SEL_S      = 3'd4
  } sel_t;

  typedef enum logic {D_IDLE, D_STREAM} dstate_t;

  logic [FW-1:0] inputf, shift, backup, e_tap;
  logic [FW-1:0] d [CH];
  logic [1:0]    eff;

  logic [AW-1:0] mem [2][DEPTH];

  logic signed [AW-1:0]  psum, psum_s, low;
  logic signed [PRW-1:0] prod;
  logic signed [SW-1:0]  sum;

  dstate_t       state, state_n;
  logic [PW-1:0] ptr, ptr_n;
  logic          done_q, done_n, err_q, err_n, bank_n;

  assign shift_w = inputf;
  assign shift_n = shift;

  // Stride values beyond the chain length clamp to the longest tap.
  always_comb begin
    eff = (32'(stride) >= 32'(MAX_STRIDE)) ? 2'(MAX_STRIDE - 1) : stride;
    e_tap = shift_e;
    for (int unsigned k = 0; k < CH; k++)
      if (MAX_STRIDE > 1 && 32'(eff) == k + 1) e_tap = d[k];
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      inputf <= '0;
      shift  <= '0;
      backup <= '0;
      for (int unsigned k = 0; k < CH; k++) d[k] <= '0;
    end else begin
      if (x_valid) backup <= x_bus;
      if (!freeze) begin
        case (in_sel)
          SEL_X: inputf <= x_bus;
          SEL_BACKUP: begin
            inputf <= backup;
            shift  <= backup;
            for (int unsigned k = 0; k < CH; k++) d[k] <= backup;
          end
          SEL_E: begin
            d[0] <= shift_e;
            for (int unsigned k = 1; k < CH; k++) d[k] <= d[k-1];
            inputf <= e_tap;
          end
          SEL_S: begin
            inputf <= shift_s;
            shift  <= shift_s;
          end
          default: ;
        endcase
      end
    end
  end

  // MAC: three AW-range terms fit in AW+2 bits, so overflow shows in the top three bits.
  always_comb begin
    psum   = mem[bank][rd_pos];
    psum_s = do_scale ? (psum >>> scale) : psum;
    low    = (IS_BOTTOM != 0) ? '0 : psum_low;
    prod   = PRW'($signed(inputf)) * PRW'($signed(w));
    sum    = SW'(psum_s) + SW'(prod) + SW'(low);
    if (sum[SW-1:AW-1] == '0 || sum[SW-1:AW-1] == '1)
      psum_up = sum[AW-1:0];
    else if (sum[SW-1])
      psum_up = {1'b1, {(AW-1){1'b0}}};
    else
      psum_up = {1'b0, {(AW-1){1'b1}}};
  end

  always_ff @(posedge clock) begin
    if (resetN && acc_we && !freeze) mem[bank][wr_pos] <= psum_up;
  end

  assign drain_data = mem[~bank][ptr];

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state  <= D_IDLE;
      ptr    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      bank   <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      done_q <= done_n;
      err_q  <= err_n;
      bank   <= bank_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    done_n  = 1'b0;
    err_n   = 1'b0;
    bank_n  = bank;
    case (state)
      D_IDLE: if (drain_start) begin
        state_n = D_STREAM;
        ptr_n   = '0;
      end
      D_STREAM: if (drain_ready) begin
        if (ptr == PW'(DEPTH - 1)) begin
          state_n = D_IDLE;
          ptr_n   = '0;
          done_n  = 1'b1;
        end else begin
          ptr_n = ptr + 1'b1;
        end
      end
      default: state_n = D_IDLE;
    endcase
    if (swap) begin
      if (state == D_IDLE && !drain_start) bank_n = ~bank;
      else err_n = 1'b1;
    end
    drain_valid = resetN && (state == D_STREAM);
    drain_busy  = resetN && (state == D_STREAM);
    drain_done  = resetN && done_q;
    swap_err    = resetN && err_q;
  end

endmodule
